sm_phase_seq: RTL and testbench

SM_PHASE_SEQ -- requirements
Module: sm_phase_seq

---
 rtl/sm_phase_seq.sv | 275 +++++++++++++++++++++++++++
 tb/tb_sm_phase_seq.sv | 466 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_phase_seq.sv
// -----------------------------------------------------------------------------
// sm_phase_seq -- stepper-motor phase sequencer with position counter.
//
// Turns a stream of step pulses into a 4-wire coil drive pattern (half- or
// full-step), tracks a signed position, honours end-stop switches and drops
// to a PWM'd holding current after a long idle period.
//
// Timing: a step edge is seen when step=1 while the registered copy of step
// is still 0. The edge, together with dir, half_mode and clr_pos, is captured
// into a request register on the clock edge that samples it. The phase,
// position, coil and blocked outputs change on the following clock edge.
//
// Parameters
//   SIZE         width of the signed position counter
//   HOLD_CYCLES  step-free cycles in RUN before dropping to HOLD
//   HOLD_DUTY    coil-on slots out of 16 while in HOLD (0..16)
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous, active-low reset
//   en         driver enable; 0 de-energises the coils
//   step       step pulse, synchronous to clk; one step per rising edge
//   dir        1 = forward, 0 = reverse
//   half_mode  1 = half-step (phase +-1), 0 = full-step (phase +-2)
//   lim_fwd    forward end-stop, active high
//   lim_rev    reverse end-stop, active high
//   clr_pos    synchronous clear of the position counter
//   coil       registered coil drive {A+, A-, B+, B-}
//   pos        registered signed position (two's complement)
//   blocked    one-cycle pulse when a step edge is rejected by an end-stop
//   fault      high while in FAULT (both end-stops active together)
// -----------------------------------------------------------------------------
module sm_phase_seq #(
  parameter int SIZE        = 16,
  parameter int HOLD_CYCLES = 50000,
  parameter int HOLD_DUTY   = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            step,
  input  logic            dir,
  input  logic            half_mode,
  input  logic            lim_fwd,
  input  logic            lim_rev,
  input  logic            clr_pos,
  output logic [3:0]      coil,
  output logic [SIZE-1:0] pos,
  output logic            blocked,
  output logic            fault
);

  // Idle counter only has to reach HOLD_CYCLES and then saturate.
  localparam int IDLE_W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(HOLD_CYCLES);

  // One extra bit so a duty of 16 (always on) compares true for every slot.
  localparam logic [4:0] PWM_DUTY = 5'(HOLD_DUTY);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // Phase-to-coil decode: eight half-step positions around one electrical turn.
  // ---------------------------------------------------------------------------
  function automatic logic [3:0] coil_of(input logic [2:0] ph);
    logic [3:0] c;
    c = 4'b0000;
    case (ph)
      3'd0: c = 4'b1000;
      3'd1: c = 4'b1010;
      3'd2: c = 4'b0010;
      3'd3: c = 4'b0110;
      3'd4: c = 4'b0100;
      3'd5: c = 4'b0101;
      3'd6: c = 4'b0001;
      3'd7: c = 4'b1001;
      default: c = 4'b0000;
    endcase
    return c;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e            state_q,    state_d;
  logic [2:0]        ph_q,       ph_d;
  logic [SIZE-1:0]   pos_q,      pos_d;
  logic              step_dly_q, step_dly_d;   // previous-cycle copy of step
  logic [IDLE_W-1:0] idle_q,     idle_d;
  logic [3:0]        pwm_q,      pwm_d;
  logic [3:0]        coil_q,     coil_d;
  logic              blocked_q,  blocked_d;
  logic              fault_q,    fault_d;

  // Step request captured on the sampling edge, applied one edge later.
  logic              req_acc_q,  req_acc_d;    // edge accepted
  logic              req_blk_q,  req_blk_d;    // edge rejected by an end-stop
  logic              req_dir_q,  req_dir_d;
  logic              req_half_q, req_half_d;
  logic              req_clr_q,  req_clr_d;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic            step_edge;
  logic            active;
  logic            both_lim;
  logic            lim_hit;
  logic            sample_ok;
  logic            apply_ok;
  logic            apply_step;
  logic [2:0]      ph_inc;
  logic [SIZE-1:0] pos_inc;

  always_comb begin
    step_edge = step & ~step_dly_q;
    active    = (state_q == ST_RUN) || (state_q == ST_HOLD);
    both_lim  = lim_fwd & lim_rev;
    lim_hit   = dir ? lim_fwd : lim_rev;

    // Edges outside RUN/HOLD, or in a cycle that is leaving RUN/HOLD for
    // OFF or FAULT, vanish without a blocked pulse.
    sample_ok = step_edge & active & en & ~both_lim;

    // A captured request is dropped if the block is leaving RUN/HOLD on
    // the edge that would apply it, so the phase stays frozen in OFF/FAULT.
    apply_ok   = active & en & ~both_lim;
    apply_step = req_acc_q & apply_ok;

    ph_inc  = req_half_q ? 3'd1 : 3'd2;
    pos_inc = req_half_q ? SIZE'(1) : SIZE'(2);
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first so no path through
    // the block leaves it unassigned; otherwise synthesis infers a latch.
    state_d    = state_q;
    ph_d       = ph_q;
    pos_d      = pos_q;
    idle_d     = idle_q;
    step_dly_d = step;
    pwm_d      = pwm_q + 4'd1;
    coil_d     = 4'b0000;
    blocked_d  = req_blk_q & apply_ok;

    req_acc_d  = sample_ok & ~lim_hit;
    req_blk_d  = sample_ok &  lim_hit;
    req_dir_d  = dir;
    req_half_d = half_mode;
    req_clr_d  = clr_pos;

    // Phase and position move together by the same signed increment;
    // the position wraps at SIZE bits with no saturation.
    if (apply_step) begin
      if (req_dir_q) begin
        ph_d  = ph_q  + ph_inc;
        pos_d = pos_q + pos_inc;
      end else begin
        ph_d  = ph_q  - ph_inc;
        pos_d = pos_q - pos_inc;
      end
    end

    // Clear wins over a coincident step for the position only; the phase
    // still advances so the rotor keeps moving.
    if (req_clr_q) begin
      pos_d = '0;
    end

    unique case (state_q)
      ST_OFF: begin
        if (en) begin
          state_d = ST_RUN;
          idle_d  = '0;
        end
      end
      ST_RUN: begin
        if (apply_step) begin
          idle_d = '0;
        end else begin
          if (idle_q != IDLE_MAX) begin
            idle_d = idle_q + IDLE_W'(1);
          end
          if (idle_d == IDLE_MAX) begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        // Wake-up and the coil update of the waking step land on one edge.
        if (apply_step) begin
          state_d = ST_RUN;
          idle_d  = '0;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_OFF;
      end
    endcase

    // Global overrides: both end-stops at once is always a fault; a low
    // enable is the only way out of FAULT and forces OFF from anywhere else.
    if (both_lim) begin
      state_d = ST_FAULT;
    end else if (!en) begin
      state_d = ST_OFF;
    end

    // Coil pattern follows the state being entered so the outputs line up
    // with the state register.
    unique case (state_d)
      ST_RUN:  coil_d = coil_of(ph_d);
      ST_HOLD: coil_d = ({1'b0, pwm_q} < PWM_DUTY) ? coil_of(ph_d) : 4'b0000;
      default: coil_d = 4'b0000;
    endcase

    fault_d = (state_d == ST_FAULT);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_OFF;
      ph_q       <= '0;
      pos_q      <= '0;
      step_dly_q <= 1'b0;
      idle_q     <= '0;
      pwm_q      <= '0;
      coil_q     <= 4'b0000;
      blocked_q  <= 1'b0;
      fault_q    <= 1'b0;
      req_acc_q  <= 1'b0;
      req_blk_q  <= 1'b0;
      req_dir_q  <= 1'b0;
      req_half_q <= 1'b0;
      req_clr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      pos_q      <= pos_d;
      step_dly_q <= step_dly_d;
      idle_q     <= idle_d;
      pwm_q      <= pwm_d;
      coil_q     <= coil_d;
      blocked_q  <= blocked_d;
      fault_q    <= fault_d;
      req_acc_q  <= req_acc_d;
      req_blk_q  <= req_blk_d;
      req_dir_q  <= req_dir_d;
      req_half_q <= req_half_d;
      req_clr_q  <= req_clr_d;
    end
  end

  assign coil    = coil_q;
  assign pos     = pos_q;
  assign blocked = blocked_q;
  assign fault   = fault_q;

endmodule

// File: tb/tb_sm_phase_seq.sv
// -----------------------------------------------------------------------------
// tb_sm_phase_seq -- self-checking bench for sm_phase_seq.
//
// Inputs are driven on the falling clock edge and outputs are sampled on the
// falling edge, half a period away from the active rising edge. A step is a
// one-cycle pulse: the DUT samples it on the next rising edge and the new
// phase/position/coil are visible one rising edge later, i.e. two falling
// edges after the pulse was driven.
//
// The reference model keeps the electrical phase and the position as plain
// integers and advances them with modular arithmetic; coil patterns come from
// a lookup table of the eight half-step positions.
// -----------------------------------------------------------------------------
module tb_sm_phase_seq;

  localparam int SIZE        = 16;
  localparam int HOLD_CYCLES = 20;
  localparam int HOLD_DUTY   = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic            step;
  logic            dir;
  logic            half_mode;
  logic            lim_fwd;
  logic            lim_rev;
  logic            clr_pos;
  logic [3:0]      coil;
  logic [SIZE-1:0] pos;
  logic            blocked;
  logic            fault;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  int m_ph  = 0;
  int m_pos = 0;
  logic [3:0] coil_tab [8] = '{4'b1000, 4'b1010, 4'b0010, 4'b0110,
                               4'b0100, 4'b0101, 4'b0001, 4'b1001};

  sm_phase_seq #(
    .SIZE        (SIZE),
    .HOLD_CYCLES (HOLD_CYCLES),
    .HOLD_DUTY   (HOLD_DUTY)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .step      (step),
    .dir       (dir),
    .half_mode (half_mode),
    .lim_fwd   (lim_fwd),
    .lim_rev   (lim_rev),
    .clr_pos   (clr_pos),
    .coil      (coil),
    .pos       (pos),
    .blocked   (blocked),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Model helpers
  // ---------------------------------------------------------------------------
  function automatic logic [3:0] exp_coil();
    return coil_tab[m_ph];
  endfunction

  function automatic logic [15:0] exp_pos();
    return 16'(m_pos);
  endfunction

  // Applies one step edge in RUN/HOLD; returns whether it was rejected.
  task automatic model_step(input bit d, input bit h, input bit clr,
                            input bit lf, input bit lr, output bit blk);
    int delta;
    blk   = d ? lf : lr;
    delta = h ? 1 : 2;
    if (!d) delta = -delta;
    if (!blk) begin
      m_ph  = (m_ph + delta) & 7;
      m_pos = (m_pos + delta) & 32'h0000_FFFF;
    end
    if (clr) m_pos = 0;
  endtask

  // Drives one step pulse starting at a falling edge and returns at the
  // falling edge where its effect is visible.
  task automatic drive_step(input bit d, input bit h, input bit clr);
    step      = 1'b1;
    dir       = d;
    half_mode = h;
    clr_pos   = clr;
    @(negedge clk);
    step      = 1'b0;
    clr_pos   = 1'b0;
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; en = 1'b0; step = 1'b0; dir = 1'b0; half_mode = 1'b0;
    lim_fwd = 1'b0; lim_rev = 1'b0; clr_pos = 1'b0;
    #1 rst = 1'b0;
    #2;  // still before the first rising clock edge
    n_checks++;
    if ({coil, pos, blocked, fault} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_async: got coil=%b pos=%h blocked=%b fault=%b expected all zero",
               coil, pos, blocked, fault);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if ({coil, pos, blocked, fault} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_held: got coil=%b pos=%h blocked=%b fault=%b expected all zero",
               coil, pos, blocked, fault);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (coil !== 4'b0000) begin
      n_fail++;
      $display("FAIL off_coil: got %b expected 0000", coil);
    end
  endtask

  task automatic test_half_fwd();
    bit blk;
    en = 1'b1;
    @(negedge clk);
    n_checks++;
    if (coil !== 4'b1000 || fault !== 1'b0) begin
      n_fail++;
      $display("FAIL run_entry: got coil=%b fault=%b expected coil=1000 fault=0", coil, fault);
    end
    for (int i = 0; i < 8; i++) begin
      drive_step(1'b1, 1'b1, 1'b0);
      model_step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, blk);
      n_checks++;
      if (coil !== exp_coil() || pos !== exp_pos()) begin
        n_fail++;
        $display("FAIL half_fwd_%0d: got coil=%b pos=%h expected coil=%b pos=%h",
                 i, coil, pos, exp_coil(), exp_pos());
      end
    end
    n_checks++;
    if (pos !== 16'd8 || coil !== 4'b1000) begin
      n_fail++;
      $display("FAIL half_fwd_end: got pos=%h coil=%b expected pos=0008 coil=1000", pos, coil);
    end
  endtask

  task automatic test_full_rev();
    bit blk;
    logic [3:0] want [3];
    want[0] = 4'b0001; want[1] = 4'b0100; want[2] = 4'b0010;
    clr_pos = 1'b1;
    @(negedge clk);
    clr_pos = 1'b0;
    @(negedge clk);
    m_pos = 0;
    n_checks++;
    if (pos !== 16'd0) begin
      n_fail++;
      $display("FAIL clr_alone: got pos=%h expected 0000", pos);
    end
    for (int i = 0; i < 3; i++) begin
      drive_step(1'b0, 1'b0, 1'b0);
      model_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, blk);
      n_checks++;
      if (coil !== want[i] || coil !== exp_coil() || pos !== exp_pos()) begin
        n_fail++;
        $display("FAIL full_rev_%0d: got coil=%b pos=%h expected coil=%b pos=%h",
                 i, coil, pos, want[i], exp_pos());
      end
    end
    n_checks++;
    if (pos !== 16'hFFFA) begin
      n_fail++;
      $display("FAIL full_rev_pos: got %h expected fffa", pos);
    end
  endtask

  task automatic test_limits();
    bit blk;
    logic [15:0] pos0;
    logic [3:0]  coil0;
    pos0  = pos;
    coil0 = coil;
    lim_fwd = 1'b1;
    step = 1'b1; dir = 1'b1; half_mode = 1'b1;
    @(negedge clk);
    step = 1'b0;
    n_checks++;
    if (blocked !== 1'b0) begin
      n_fail++;
      $display("FAIL blocked_early: got %b expected 0", blocked);
    end
    @(negedge clk);
    n_checks++;
    if (blocked !== 1'b1 || pos !== pos0 || coil !== coil0) begin
      n_fail++;
      $display("FAIL blocked_pulse: got blocked=%b pos=%h coil=%b expected 1 %h %b",
               blocked, pos, coil, pos0, coil0);
    end
    @(negedge clk);
    n_checks++;
    if (blocked !== 1'b0) begin
      n_fail++;
      $display("FAIL blocked_width: got %b expected 0", blocked);
    end
    drive_step(1'b0, 1'b1, 1'b0);
    model_step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, blk);
    n_checks++;
    if (pos !== pos0 - 16'd1 || pos !== exp_pos() || coil !== exp_coil() || blocked !== 1'b0) begin
      n_fail++;
      $display("FAIL rev_past_fwd_lim: got pos=%h coil=%b blocked=%b expected pos=%h coil=%b",
               pos, coil, blocked, exp_pos(), exp_coil());
    end
    lim_fwd = 1'b0;
  endtask

  // Entered straight after the falling edge at which the last step became
  // visible, i.e. the rising edge just before reset the idle count to zero.
  task automatic test_hold();
    bit blk;
    int run_bad = 0;
    int on_16 = 0;
    int on_32 = 0;
    int odd_pat = 0;
    for (int i = 1; i < HOLD_CYCLES; i++) begin
      @(negedge clk);
      if (coil !== exp_coil()) run_bad++;
    end
    n_checks++;
    if (run_bad != 0) begin
      n_fail++;
      $display("FAIL run_before_hold: got %0d gated cycles expected 0", run_bad);
    end
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (coil !== 4'b0000) begin
        on_32++;
        if (i < 16) on_16++;
        if (coil !== exp_coil()) odd_pat++;
      end
    end
    n_checks++;
    if (on_16 != HOLD_DUTY) begin
      n_fail++;
      $display("FAIL hold_duty16: got %0d on-cycles expected %0d", on_16, HOLD_DUTY);
    end
    n_checks++;
    if (on_32 != 2 * HOLD_DUTY) begin
      n_fail++;
      $display("FAIL hold_duty32: got %0d on-cycles expected %0d", on_32, 2 * HOLD_DUTY);
    end
    n_checks++;
    if (odd_pat != 0) begin
      n_fail++;
      $display("FAIL hold_pattern: got %0d wrong patterns expected 0", odd_pat);
    end
    drive_step(1'b1, 1'b1, 1'b0);
    model_step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, blk);
    n_checks++;
    if (coil !== exp_coil() || pos !== exp_pos()) begin
      n_fail++;
      $display("FAIL hold_wake: got coil=%b pos=%h expected coil=%b pos=%h",
               coil, pos, exp_coil(), exp_pos());
    end
    run_bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (coil !== exp_coil()) run_bad++;
    end
    n_checks++;
    if (run_bad != 0) begin
      n_fail++;
      $display("FAIL wake_continuous: got %0d gated cycles expected 0", run_bad);
    end
  endtask

  task automatic test_fault();
    logic [15:0] pos0;
    pos0 = pos;
    lim_fwd = 1'b1; lim_rev = 1'b1;
    @(negedge clk);
    n_checks++;
    if (fault !== 1'b1 || coil !== 4'b0000) begin
      n_fail++;
      $display("FAIL fault_entry: got fault=%b coil=%b expected 1 0000", fault, coil);
    end
    drive_step(1'b1, 1'b1, 1'b0);
    n_checks++;
    if (pos !== pos0 || blocked !== 1'b0 || fault !== 1'b1) begin
      n_fail++;
      $display("FAIL fault_step_lims: got pos=%h blocked=%b fault=%b expected %h 0 1",
               pos, blocked, fault, pos0);
    end
    lim_fwd = 1'b0; lim_rev = 1'b0;
    @(negedge clk);
    n_checks++;
    if (fault !== 1'b1) begin
      n_fail++;
      $display("FAIL fault_sticky: got %b expected 1", fault);
    end
    drive_step(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (pos !== pos0 || blocked !== 1'b0 || coil !== 4'b0000) begin
      n_fail++;
      $display("FAIL fault_step: got pos=%h blocked=%b coil=%b expected %h 0 0000",
               pos, blocked, coil, pos0);
    end
    en = 1'b0;
    @(negedge clk);
    n_checks++;
    if (fault !== 1'b0 || coil !== 4'b0000) begin
      n_fail++;
      $display("FAIL fault_to_off: got fault=%b coil=%b expected 0 0000", fault, coil);
    end
    en = 1'b1;
    @(negedge clk);
    n_checks++;
    if (coil !== exp_coil() || pos !== pos0 || fault !== 1'b0) begin
      n_fail++;
      $display("FAIL off_to_run: got coil=%b pos=%h expected coil=%b pos=%h",
               coil, pos, exp_coil(), pos0);
    end
  endtask

  task automatic test_random();
    bit d, h, clr, lf, lr, blk;
    bit prev_rej = 1'b0;
    int r;
    int gap;
    for (int i = 0; i < 80; i++) begin
      d   = 1'($urandom_range(0, 1));
      h   = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 7) == 0);
      r   = $urandom_range(0, 7);
      lf  = !prev_rej && (r == 0 || r == 2);
      lr  = !prev_rej && (r == 1 || r == 3);
      lim_fwd = lf;
      lim_rev = lr;
      drive_step(d, h, clr);
      model_step(d, h, clr, lf, lr, blk);
      prev_rej = blk;
      n_checks++;
      if (blocked !== blk || pos !== exp_pos() || coil !== exp_coil()) begin
        n_fail++;
        $display("FAIL rand_%0d: d=%b h=%b clr=%b lf=%b lr=%b got blocked=%b pos=%h coil=%b expected %b %h %b",
                 i, d, h, clr, lf, lr, blocked, pos, coil, blk, exp_pos(), exp_coil());
      end
      lim_fwd = 1'b0;
      lim_rev = 1'b0;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        n_checks++;
        if (blocked !== 1'b0 || pos !== exp_pos()) begin
          n_fail++;
          $display("FAIL rand_gap_%0d: got blocked=%b pos=%h expected 0 %h",
                   i, blocked, pos, exp_pos());
        end
      end
    end
  endtask

  task automatic test_wrap_clr();
    bit blk;
    clr_pos = 1'b1;
    @(negedge clk);
    clr_pos = 1'b0;
    @(negedge clk);
    m_pos = 0;
    drive_step(1'b1, 1'b1, 1'b0);
    model_step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, blk);
    for (int i = 0; i < 16383; i++) begin
      drive_step(1'b1, 1'b0, 1'b0);
      model_step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, blk);
    end
    n_checks++;
    if (pos !== 16'h7FFF || coil !== exp_coil()) begin
      n_fail++;
      $display("FAIL pos_7fff: got pos=%h coil=%b expected 7fff %b", pos, coil, exp_coil());
    end
    drive_step(1'b1, 1'b1, 1'b0);
    model_step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, blk);
    n_checks++;
    if (pos !== 16'h8000 || coil !== exp_coil()) begin
      n_fail++;
      $display("FAIL pos_wrap: got pos=%h coil=%b expected 8000 %b", pos, coil, exp_coil());
    end
    drive_step(1'b1, 1'b1, 1'b1);
    model_step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, blk);
    n_checks++;
    if (pos !== 16'h0000 || coil !== exp_coil()) begin
      n_fail++;
      $display("FAIL clr_with_step: got pos=%h coil=%b expected 0000 %b", pos, coil, exp_coil());
    end
    drive_step(1'b1, 1'b1, 1'b0);
    model_step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, blk);
  endtask

  task automatic test_async_reset();
    bit blk;
    step = 1'b1; dir = 1'b1; half_mode = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({coil, pos, blocked, fault} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_mid_run: got coil=%b pos=%h blocked=%b fault=%b expected all zero",
               coil, pos, blocked, fault);
    end
    m_ph = 0;
    m_pos = 0;
    @(negedge clk);
    rst = 1'b1;  // step still held high across the release
    repeat (3) @(negedge clk);
    n_checks++;
    if (coil !== 4'b1000 || pos !== 16'd0 || blocked !== 1'b0) begin
      n_fail++;
      $display("FAIL held_step_after_reset: got coil=%b pos=%h blocked=%b expected 1000 0000 0",
               coil, pos, blocked);
    end
    step = 1'b0;
    @(negedge clk);
    drive_step(1'b1, 1'b1, 1'b0);
    model_step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, blk);
    n_checks++;
    if (coil !== exp_coil() || pos !== exp_pos()) begin
      n_fail++;
      $display("FAIL step_after_reset: got coil=%b pos=%h expected %b %h",
               coil, pos, exp_coil(), exp_pos());
    end
  endtask

  initial begin
    test_reset();
    test_half_fwd();
    test_full_rev();
    test_limits();
    test_hold();
    test_fault();
    test_random();
    test_wrap_clr();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
